// File: rtl/mix_freq_nch.sv
// N-channel IQ down-mixer: one shared 2-stage multiplier walks CH channels x {I,Q} per input beat,
// decimates, streams IQ results and keeps snapshot-and-clear accumulators. Saturating outputs: MIX_FREQ_NCH_SAT_EN.
module mix_freq_nch #(
  parameter int DW    = 16,
  parameter int CH    = 2,
  parameter int ACC_W = 40,
  parameter int CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                      clk1,
  input  logic                      rst_n,
  input  logic                      pcm_in_valid,
  output logic                      pcm_in_ready,
  input  logic [CH*DW-1:0]          pcm_in,
  input  logic [DW-1:0]             lo_i,
  input  logic [DW-1:0]             lo_q,
  output logic                      lo_next,
  output logic                      iq_out_valid,
  input  logic                      iq_out_ready,
  output logic [CW-1:0]             iq_out_ch,
  output logic [DW-1:0]             iq_out_i,
  output logic [DW-1:0]             iq_out_q,
  input  logic                      acc_snap,
  output logic [CH*(ACC_W-8)-1:0]   acc_i_out,
  output logic [CH*(ACC_W-8)-1:0]   acc_q_out,
  input  logic [4:0]                pcm_out_shift,
  input  logic [4:0]                acc_shift,
  input  logic [7:0]                dec_rate,
  input  logic                      resync
);

  localparam int SLOTS = 2 * CH;
  localparam int SW    = $clog2(SLOTS);
  localparam int PW    = 2 * DW;
  localparam int AOW   = ACC_W - 8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_EMIT} state_t;

  state_t r_state, w_next;

  logic [CH*DW-1:0]          r_pcm;
  logic [DW-1:0]             r_lo_i, r_lo_q;
  logic                      r_hit;
  logic [7:0]                r_dec_cnt;
  logic [SW-1:0]             r_slot;
  logic                      r_drain;
  logic                      r_rdy_en;

  logic                      r_p1_vld, r_p2_vld;
  logic [SW-1:0]             r_p1_slot, r_p2_slot;
  logic signed [DW-1:0]      r_p1_a, r_p1_b;
  logic signed [PW-1:0]      r_p2_prod;

  logic [DW-1:0]             r_res_i [CH];
  logic [DW-1:0]             r_res_q [CH];
  logic signed [ACC_W-1:0]   r_acc_i [CH];
  logic signed [ACC_W-1:0]   r_acc_q [CH];
  logic [AOW-1:0]            r_snap_i [CH];
  logic [AOW-1:0]            r_snap_q [CH];

  logic                      r_out_valid;
  logic [CW-1:0]             r_out_ch;
  logic [DW-1:0]             r_out_i, r_out_q;

  logic                      w_hs;
  logic                      w_out_hs;
  logic                      w_last_ch;
  logic [CW-1:0]             w_nxt_ch;
  logic signed [DW-1:0]      w_op_a, w_op_b;
  logic signed [PW-1:0]      w_p_acc;
  logic signed [ACC_W-1:0]   w_addend;
  logic [DW-1:0]             w_out_val;
`ifdef MIX_FREQ_NCH_SAT_EN
  logic signed [PW-1:0]      w_p_out;
`endif

  assign pcm_in_ready = (r_state == S_IDLE) && r_rdy_en && !resync;
  assign w_hs         = pcm_in_valid && pcm_in_ready;
  assign lo_next      = w_hs;
  assign w_out_hs     = r_out_valid && iq_out_ready;
  assign w_last_ch    = (r_out_ch == CW'(CH - 1));
  assign w_nxt_ch     = r_out_ch + 1'b1;

  assign iq_out_valid = r_out_valid;
  assign iq_out_ch    = r_out_ch;
  assign iq_out_i     = r_out_i;
  assign iq_out_q     = r_out_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (resync) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_MUL;
      S_MUL:   if (r_slot == SW'(SLOTS - 1)) w_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_next = r_hit ? S_EMIT : S_IDLE;
      S_EMIT:  if (w_out_hs && w_last_ch) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Beat capture, decimation decision and slot sequencing.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_pcm     <= '0;
      r_lo_i    <= '0;
      r_lo_q    <= '0;
      r_hit     <= 1'b0;
      r_dec_cnt <= '0;
      r_slot    <= '0;
      r_drain   <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else if (resync) begin
      r_hit     <= 1'b0;
      r_dec_cnt <= '0;
      r_slot    <= '0;
      r_drain   <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_hs) begin
        r_pcm  <= pcm_in;
        r_lo_i <= lo_i;
        r_lo_q <= lo_q;
        // A counter left above a freshly lowered dec_rate counts as a hit.
        if (r_dec_cnt >= dec_rate) begin
          r_hit     <= 1'b1;
          r_dec_cnt <= '0;
        end else begin
          r_hit     <= 1'b0;
          r_dec_cnt <= r_dec_cnt + 8'd1;
        end
      end
      r_slot  <= (r_state == S_MUL) ? r_slot + 1'b1 : '0;
      r_drain <= (r_state == S_DRAIN) ? !r_drain : 1'b0;
    end
  end

  always_comb begin
    w_op_a = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if ((32'(r_slot) >> 1) == k) w_op_a = r_pcm[k*DW +: DW];
    end
    w_op_b = r_slot[0] ? r_lo_q : r_lo_i;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld  <= 1'b0;
      r_p1_slot <= '0;
      r_p1_a    <= '0;
      r_p1_b    <= '0;
      r_p2_vld  <= 1'b0;
      r_p2_slot <= '0;
      r_p2_prod <= '0;
    end else if (resync) begin
      r_p1_vld  <= 1'b0;
      r_p2_vld  <= 1'b0;
    end else begin
      r_p1_vld  <= (r_state == S_MUL);
      r_p1_slot <= r_slot;
      r_p1_a    <= w_op_a;
      r_p1_b    <= w_op_b;
      r_p2_vld  <= r_p1_vld;
      r_p2_slot <= r_p1_slot;
      r_p2_prod <= PW'(r_p1_a) * PW'(r_p1_b);
    end
  end

  always_comb begin
    w_p_acc  = r_p2_prod >>> acc_shift;
    w_addend = ACC_W'(w_p_acc);
`ifdef MIX_FREQ_NCH_SAT_EN
    w_p_out = r_p2_prod >>> pcm_out_shift;
    if (w_p_out[PW-1:DW-1] == '0 || w_p_out[PW-1:DW-1] == '1)
      w_out_val = w_p_out[DW-1:0];
    else if (w_p_out[PW-1])
      w_out_val = {1'b1, {(DW-1){1'b0}}};
    else
      w_out_val = {1'b0, {(DW-1){1'b1}}};
`else
    w_out_val = DW'(r_p2_prod >>> pcm_out_shift);
`endif
  end

  // On a snapshot coinciding with an add, the add seeds the cleared accumulator.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CH; k++) begin
        r_res_i[k]  <= '0;
        r_res_q[k]  <= '0;
        r_acc_i[k]  <= '0;
        r_acc_q[k]  <= '0;
        r_snap_i[k] <= '0;
        r_snap_q[k] <= '0;
      end
    end else if (resync) begin
      for (int unsigned k = 0; k < CH; k++) begin
        r_acc_i[k]  <= '0;
        r_acc_q[k]  <= '0;
        r_snap_i[k] <= '0;
        r_snap_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        logic w_sel, w_add_i, w_add_q;
        w_sel   = r_p2_vld && ((32'(r_p2_slot) >> 1) == k);
        w_add_i = w_sel && !r_p2_slot[0];
        w_add_q = w_sel &&  r_p2_slot[0];
        if (w_add_i) r_res_i[k] <= w_out_val;
        if (w_add_q) r_res_q[k] <= w_out_val;
        if (acc_snap) begin
          r_snap_i[k] <= r_acc_i[k][ACC_W-1:8];
          r_snap_q[k] <= r_acc_q[k][ACC_W-1:8];
          r_acc_i[k]  <= w_add_i ? w_addend : '0;
          r_acc_q[k]  <= w_add_q ? w_addend : '0;
        end else begin
          if (w_add_i) r_acc_i[k] <= r_acc_i[k] + w_addend;
          if (w_add_q) r_acc_q[k] <= r_acc_q[k] + w_addend;
        end
      end
    end
  end

  always_comb begin
    acc_i_out = '0;
    acc_q_out = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      acc_i_out[k*AOW +: AOW] = r_snap_i[k];
      acc_q_out[k*AOW +: AOW] = r_snap_q[k];
    end
  end

  // EMIT is always entered with the output idle, so an idle output there means "load channel 0".
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else if (resync) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else if (r_state == S_EMIT) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= '0;
        r_out_i     <= r_res_i[0];
        r_out_q     <= r_res_q[0];
      end else if (iq_out_ready) begin
        if (w_last_ch) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_ch <= w_nxt_ch;
          r_out_i  <= r_res_i[w_nxt_ch];
          r_out_q  <= r_res_q[w_nxt_ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_mix_freq_nch.sv
// Scoreboard bench for mix_freq_nch (CH=2, DW=16): directed beats push expected IQ sets,
// a negedge monitor pops and compares on every output handshake.
module tb_mix_freq_nch;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int ACC_W = 40;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              pcm_in_valid;
  logic              pcm_in_ready;
  logic [CH*DW-1:0]  pcm_in;
  logic [DW-1:0]     lo_i, lo_q;
  logic              lo_next;
  logic              iq_out_valid;
  logic              iq_out_ready;
  logic [0:0]        iq_out_ch;
  logic [DW-1:0]     iq_out_i, iq_out_q;
  logic              acc_snap;
  logic [63:0]       acc_i_out, acc_q_out;
  logic [4:0]        pcm_out_shift, acc_shift;
  logic [7:0]        dec_rate;
  logic              resync;

  mix_freq_nch #(.DW(DW), .CH(CH), .ACC_W(ACC_W), .CW(1)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .pcm_in_valid(pcm_in_valid), .pcm_in_ready(pcm_in_ready), .pcm_in(pcm_in),
    .lo_i(lo_i), .lo_q(lo_q), .lo_next(lo_next),
    .iq_out_valid(iq_out_valid), .iq_out_ready(iq_out_ready), .iq_out_ch(iq_out_ch),
    .iq_out_i(iq_out_i), .iq_out_q(iq_out_q),
    .acc_snap(acc_snap), .acc_i_out(acc_i_out), .acc_q_out(acc_q_out),
    .pcm_out_shift(pcm_out_shift), .acc_shift(acc_shift), .dec_rate(dec_rate), .resync(resync)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed { logic [0:0] ch; logic [15:0] i; logic [15:0] q; } exp_t;
  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lo_cnt = 0;
  int   valid_cycles = 0;
  logic prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (!rst_n || resync) begin
      prev_stall = 1'b0;
    end else begin
      if (lo_next) lo_cnt++;
      if (iq_out_valid) valid_cycles++;
      if (prev_stall)
        chk("hold_stable", {iq_out_valid, iq_out_ch, iq_out_i, iq_out_q}, {1'b1, prev_out});
      if (iq_out_valid && iq_out_ready) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got ch%0d i=0x%0h q=0x%0h expected no output",
                   iq_out_ch, iq_out_i, iq_out_q);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("out_ch", 64'(iq_out_ch), 64'(e.ch));
          chk("out_i",  64'(iq_out_i),  64'(e.i));
          chk("out_q",  64'(iq_out_q),  64'(e.q));
        end
      end
      prev_stall = iq_out_valid && !iq_out_ready;
      prev_out   = {iq_out_ch, iq_out_i, iq_out_q};
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] pcm, input logic [15:0] li, input logic [15:0] lq);
    int n;
    n = 0;
    pcm_in = pcm;
    lo_i = li;
    lo_q = lq;
    pcm_in_valid = 1'b1;
    @(negedge clk1);
    while (!pcm_in_ready && n < 300) begin
      @(negedge clk1);
      n++;
    end
    if (!pcm_in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 300 cycles");
      pcm_in_valid = 1'b0;
    end else begin
      @(posedge clk1);
      #1;
      pcm_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_exp.size() != 0 || iq_out_valid || !pcm_in_ready) && n < 500) begin
      @(posedge clk1);
      #1;
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_exp.size());
    end
  endtask

  task automatic push_set(input logic [15:0] i0, input logic [15:0] q0,
                          input logic [15:0] i1, input logic [15:0] q1);
    q_exp.push_back('{ch: 1'b0, i: i0, q: q0});
    q_exp.push_back('{ch: 1'b1, i: i1, q: q1});
  endtask

  task automatic snap_pulse();
    acc_snap = 1'b1;
    @(posedge clk1);
    #1;
    acc_snap = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo0, vc0, lat, rdy_hi;
    rst_n = 1'b0; resync = 1'b0;
    pcm_in_valid = 1'b0; pcm_in = '0; lo_i = '0; lo_q = '0;
    iq_out_ready = 1'b1; acc_snap = 1'b0;
    pcm_out_shift = 5'd15; acc_shift = 5'd0; dec_rate = 8'd0;

    repeat (3) @(posedge clk1);
    #1;
    chk("rst_ready", 64'(pcm_in_ready), 64'd0);
    chk("rst_valid", 64'(iq_out_valid), 64'd0);
    chk("rst_acc", acc_i_out | acc_q_out, 64'd0);
    rst_n = 1'b1;
    cycles(1);
    chk("ready_after_rst", 64'(pcm_in_ready), 64'd1);

    // Basic mix: ch0 0x1000, ch1 0x2000 against LO (0x4000, -0x4000), shift 15.
    push_set(16'h0800, 16'hF800, 16'h1000, 16'hF000);
    lo0 = lo_cnt;
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk1);
      #1;
      if (iq_out_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd7);
    wait_drain();
    chk("lo_next_single", 64'(lo_cnt - lo0), 64'd1);

    // Decimation by 4: only beats 4 and 8 emit.
    dec_rate = 8'd3;
    lo0 = lo_cnt;
    vc0 = valid_cycles;
    for (int b = 1; b <= 8; b++) begin
      if (b == 4 || b == 8) push_set(16'h0800, 16'hF800, 16'h1000, 16'hF000);
      send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    end
    wait_drain();
    chk("dec_lo_next", 64'(lo_cnt - lo0), 64'd8);
    chk("dec_out_beats", 64'(valid_cycles - vc0), 64'd4);

    // Lowering dec_rate below the running count forces a hit on the next beat.
    vc0 = valid_cycles;
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    wait_drain();
    dec_rate = 8'd1;
    push_set(16'h0800, 16'hF800, 16'h1000, 16'hF000);
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    wait_drain();
    chk("dec_change_beats", 64'(valid_cycles - vc0), 64'd2);

    // Backpressure on a hit.
    dec_rate = 8'd0;
    push_set(16'h0800, 16'hF800, 16'h1000, 16'hF000);
    iq_out_ready = 1'b0;
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    rdy_hi = 0;
    for (int c = 0; c < 27; c++) begin
      @(posedge clk1);
      #1;
      if (pcm_in_ready) rdy_hi++;
    end
    chk("bp_ready_low", 64'(rdy_hi), 64'd0);
    chk("bp_valid", 64'(iq_out_valid), 64'd1);
    chk("bp_ch0_i", {47'd0, iq_out_ch, iq_out_i}, 64'h0000_0000_0000_0800);
    iq_out_ready = 1'b1;
    wait_drain();

    // Accumulators: P_I = 0x4000*0x1000 = 0x04000000 per beat on ch0.
    dec_rate = 8'd255;
    acc_shift = 5'd0;
    snap_pulse();
    for (int b = 0; b < 4; b++) send_beat(32'h0000_4000, 16'h1000, 16'h0000);
    cycles(10);
    snap_pulse();
    chk("acc_snap_ch0_i", 64'(acc_i_out[31:0]), 64'h0010_0000);
    chk("acc_snap_ch0_q", 64'(acc_q_out[31:0]), 64'd0);
    chk("acc_snap_ch1_i", 64'(acc_i_out[63:32]), 64'd0);
    snap_pulse();
    chk("acc_cleared", 64'(acc_i_out[31:0]), 64'd0);
    for (int b = 0; b < 4; b++) send_beat(32'h0000_4000, 16'h1000, 16'h0000);
    send_beat(32'h0000_4000, 16'h1000, 16'h0000);
    repeat (2) @(posedge clk1);
    #1;
    snap_pulse();
    chk("acc_snap_coincident", 64'(acc_i_out[31:0]), 64'h0010_0000);
    cycles(10);
    snap_pulse();
    chk("acc_seeded_addend", 64'(acc_i_out[31:0]), 64'h0004_0000);

    // Overrange output: 0x7FFF*0x7FFF and -0x7FFF*0x7FFF with shift 0.
    dec_rate = 8'd0;
    pcm_out_shift = 5'd0;
`ifdef MIX_FREQ_NCH_SAT_EN
    push_set(16'h7FFF, 16'h0000, 16'h8000, 16'h0000);
`else
    push_set(16'h0001, 16'h0000, 16'hFFFF, 16'h0000);
`endif
    send_beat(32'h8001_7FFF, 16'h7FFF, 16'h0000);
    wait_drain();
    pcm_out_shift = 5'd15;

    // Async reset during MUL.
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    cycles(2);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 64'(iq_out_valid), 64'd0);
    chk("arst_out_i", 64'(iq_out_i), 64'd0);
    chk("arst_ready", 64'(pcm_in_ready), 64'd0);
    chk("arst_lo_next", 64'(lo_next), 64'd0);
    chk("arst_acc", acc_i_out, 64'd0);
    cycles(1);
    rst_n = 1'b1;
    vc0 = valid_cycles;
    cycles(20);
    chk("arst_no_emit", 64'(valid_cycles - vc0), 64'd0);
    chk("arst_ready_after", 64'(pcm_in_ready), 64'd1);

    // Recovery, then resync during MUL.
    push_set(16'h0800, 16'hF800, 16'h1000, 16'hF000);
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    wait_drain();
    snap_pulse();
    chk("pre_resync_acc", 64'(acc_i_out[31:0]), 64'h0004_0000);
    send_beat(32'h2000_1000, 16'h4000, 16'hC000);
    cycles(2);
    resync = 1'b1;
    cycles(1);
    chk("resync_valid", 64'(iq_out_valid), 64'd0);
    chk("resync_out_i", 64'(iq_out_i), 64'd0);
    chk("resync_ready", 64'(pcm_in_ready), 64'd0);
    chk("resync_acc", acc_i_out, 64'd0);
    resync = 1'b0;
    vc0 = valid_cycles;
    cycles(20);
    chk("resync_no_emit", 64'(valid_cycles - vc0), 64'd0);
    chk("resync_ready_after", 64'(pcm_in_ready), 64'd1);

    chk("queue_empty", 64'(q_exp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
